l2_port_arbiter: RTL and testbench

- Shares the single line-based L2 port among NUM_REQ L1 caches, one per core, in the MSI coherence subsystem.
- Each requester side presents the same signals an L1 drives toward L2: addr, line wdata, rd/wr held high until ready, ready pulse, and line rdata.
- Arbitration is round-robin and non-preemptive: one transaction at a time, locked from grant until completion.
- A watchdog completes any transaction that L2 never acknowledges.

---
 rtl/l2_port_arbiter_pkg.sv | 20 ++
 rtl/l2_port_arbiter_if.sv | 35 +++
 rtl/l2_port_arbiter_rr_pick.sv | 33 +++
 rtl/l2_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_l2_port_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_port_arbiter_pkg.sv
// Shared defaults, state encoding and sizing helpers for the L2 port arbiter.
package l2_port_arbiter_pkg;

  localparam int unsigned L1_LINE_SIZE       = 64;
  localparam int unsigned ARB_NUM_REQ        = 4;
  localparam int unsigned ARB_TIMEOUT_CYCLES = 1024;
  localparam int unsigned ADDR_W             = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // Watchdog counter width; a disabled watchdog still keeps a 1-bit counter.
  function automatic int unsigned wd_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/l2_port_arbiter_if.sv
// Requester-side and L2-side bus bundle for the L2 port arbiter.
interface l2_port_arbiter_if
  import l2_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = ARB_NUM_REQ,
  parameter int unsigned LINE_BITS = L1_LINE_SIZE * 8
);

  logic [NUM_REQ*ADDR_W-1:0]    req_addr;
  logic [NUM_REQ*LINE_BITS-1:0] req_wdata;
  logic [NUM_REQ-1:0]           req_rd;
  logic [NUM_REQ-1:0]           req_wr;
  logic [LINE_BITS-1:0]         req_rdata;
  logic [NUM_REQ-1:0]           req_ready;

  logic [ADDR_W-1:0]            mem_addr;
  logic [LINE_BITS-1:0]         mem_wdata;
  logic                         mem_rd;
  logic                         mem_wr;
  logic [LINE_BITS-1:0]         mem_rdata;
  logic                         mem_ready;

  // Environment view: the L1 caches and the L2 port.
  modport master (
    output req_addr, req_wdata, req_rd, req_wr, mem_rdata, mem_ready,
    input  req_rdata, req_ready, mem_addr, mem_wdata, mem_rd, mem_wr
  );

  // Arbiter view.
  modport slave (
    input  req_addr, req_wdata, req_rd, req_wr, mem_rdata, mem_ready,
    output req_rdata, req_ready, mem_addr, mem_wdata, mem_rd, mem_wr
  );

endinterface

// File: rtl/l2_port_arbiter_rr_pick.sv
// Combinational round-robin select: first active request at or after ptr_i.
module l2_port_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned GRANT_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic [GRANT_W-1:0] winner_o_c,
  output logic               valid_o_c
);

  int unsigned idx_c;
  logic        found_c;

  // Walk ptr, ptr+1, ... modulo NUM_REQ and keep the first active index.
  always_comb begin
    idx_c      = 0;
    found_c    = 1'b0;
    winner_o_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_c = 32'(ptr_i) + k;
      if (idx_c >= NUM_REQ) begin
        idx_c = idx_c - NUM_REQ;
      end
      if (!found_c && req_i[GRANT_W'(idx_c)]) begin
        found_c    = 1'b1;
        winner_o_c = GRANT_W'(idx_c);
      end
    end
    valid_o_c = found_c;
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one L2 line port among L1 caches.
module l2_port_arbiter
  import l2_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = ARB_NUM_REQ,
  parameter int unsigned LINE_SIZE      = L1_LINE_SIZE,
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES,
  parameter int unsigned GRANT_W        = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  l2_port_arbiter_if.slave   bus,
  output logic [GRANT_W-1:0] grant_id,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned        LINE_BITS = LINE_SIZE * 8;
  localparam int unsigned        WD_W      = wd_width(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GRANT_W-1:0] LAST_ID   = GRANT_W'(NUM_REQ - 1);
  localparam logic               WD_EN     = (TIMEOUT_CYCLES != 0);

  arb_state_e               state_q, state_d;
  logic [GRANT_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [GRANT_W-1:0]       grant_q, grant_d;
  logic                     busy_q, busy_d;
  logic                     timeout_err_q, timeout_err_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0]     mem_wdata_q, mem_wdata_d;
  logic                     mem_rd_q, mem_rd_d;
  logic                     mem_wr_q, mem_wr_d;
  logic [NUM_REQ-1:0]       req_ready_q, req_ready_d;
  logic [LINE_BITS-1:0]     req_rdata_q, req_rdata_d;
  logic [WD_W-1:0]          wd_cnt_q, wd_cnt_d;

  logic [NUM_REQ-1:0]       req_active_c;
  logic [GRANT_W-1:0]       win_c;
  logic                     win_valid_c;
  logic [ADDR_W-1:0]        sel_addr_c;
  logic [LINE_BITS-1:0]     sel_wdata_c;
  logic                     sel_rd_c;
  logic                     sel_wr_c;
  logic                     wd_expire_c;

  assign req_active_c = bus.req_rd | bus.req_wr;

  l2_port_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_rr_pick (
    .req_i      (req_active_c),
    .ptr_i      (rr_ptr_q),
    .winner_o_c (win_c),
    .valid_o_c  (win_valid_c)
  );

  // Route the winning requester's slice toward the L2 latches.
  always_comb begin
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    sel_rd_c    = 1'b0;
    sel_wr_c    = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win_c == GRANT_W'(i)) begin
        sel_addr_c  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata_c = bus.req_wdata[i*LINE_BITS +: LINE_BITS];
        sel_rd_c    = bus.req_rd[i];
        sel_wr_c    = bus.req_wr[i];
      end
    end
  end

  // Watchdog fires on the last allowed BUSY cycle when enabled.
  always_comb begin
    wd_expire_c = WD_EN && (wd_cnt_q == WD_LAST);
  end

  // Next-state and output-register logic for IDLE -> BUSY -> RELEASE.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    busy_d        = busy_q;
    timeout_err_d = timeout_err_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_rd_d      = mem_rd_q;
    mem_wr_d      = mem_wr_q;
    req_ready_d   = '0;
    req_rdata_d   = req_rdata_q;
    wd_cnt_d      = wd_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_valid_c) begin
          grant_d     = win_c;
          busy_d      = 1'b1;
          mem_addr_d  = sel_addr_c;
          mem_wdata_d = sel_wdata_c;
          mem_rd_d    = sel_rd_c;
          mem_wr_d    = sel_wr_c & ~sel_rd_c;
          wd_cnt_d    = '0;
          state_d     = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (bus.mem_ready || wd_expire_c) begin
          mem_rd_d      = 1'b0;
          mem_wr_d      = 1'b0;
          req_rdata_d   = (bus.mem_ready && mem_rd_q) ? bus.mem_rdata : '0;
          timeout_err_d = timeout_err_q | ~bus.mem_ready;
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_ready_d[i] = (grant_q == GRANT_W'(i));
          end
          rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + GRANT_W'(1);
          state_d  = ST_RELEASE;
        end else if (wd_cnt_q != {WD_W{1'b1}}) begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end

      ST_RELEASE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight L2 access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      req_ready_q   <= '0;
      req_rdata_q   <= '0;
      wd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
      req_ready_q   <= req_ready_d;
      req_rdata_q   <= req_rdata_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.req_ready = req_ready_q;
  assign bus.req_rdata = req_rdata_q;
  assign grant_id      = grant_q;
  assign busy          = busy_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: reset, reads, contention, fairness, writes, watchdog.
module tb_l2_port_arbiter;
  import l2_port_arbiter_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned LB = L1_LINE_SIZE * 8;
  localparam int unsigned GW = 2;
  localparam logic [LB-1:0] PAT_A5 = {L1_LINE_SIZE{8'hA5}};
  localparam logic [LB-1:0] PAT_5A = {L1_LINE_SIZE{8'h5A}};
  localparam logic [LB-1:0] PAT_C3 = {L1_LINE_SIZE{8'hC3}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [GW-1:0] grant_id;
  logic          busy;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;
  int ready_cnt [NR];
  int multi_hot = 0;

  always #5 clk = ~clk;

  l2_port_arbiter_if #(.NUM_REQ(NR), .LINE_BITS(LB)) bus ();

  l2_port_arbiter #(
    .NUM_REQ        (NR),
    .LINE_SIZE      (L1_LINE_SIZE),
    .TIMEOUT_CYCLES (16),
    .GRANT_W        (GW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // Count completion pulses per requester and any multi-hot pulse.
  always @(posedge clk) begin
    if ($countones(bus.req_ready) > 1) multi_hot++;
    for (int i = 0; i < int'(NR); i++) if (bus.req_ready[i]) ready_cnt[i]++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_rd    = '0;
    bus.req_wr    = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    tick(2);
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for an L2 strobe, ack it after 'delay' cycles, capture results.
  task automatic run_txn(input int unsigned delay, input logic [LB-1:0] rdata,
                         output bit seen, output int unsigned lat,
                         output logic [GW-1:0] gid, output logic [31:0] addr,
                         output logic rd, output logic wr, output logic [LB-1:0] wdata,
                         output logic [NR-1:0] rdy, output logic [LB-1:0] rdat);
    seen = 1'b0;
    lat  = 0;
    for (int n = 0; n < 12 && !seen; n++) begin
      tick(1);
      lat++;
      if (bus.mem_rd || bus.mem_wr) seen = 1'b1;
    end
    gid   = grant_id;
    addr  = bus.mem_addr;
    rd    = bus.mem_rd;
    wr    = bus.mem_wr;
    wdata = bus.mem_wdata;
    rdy   = '0;
    rdat  = '0;
    if (seen) begin
      repeat (delay - 1) tick(1);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = rdata;
      tick(1);
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      rdy  = bus.req_ready;
      rdat = bus.req_rdata;
    end
  endtask

  task automatic test_reset();
    total++;
    if ({bus.req_ready, bus.mem_rd, bus.mem_wr, grant_id, busy, timeout_err} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl got=%0h exp=0",
               {bus.req_ready, bus.mem_rd, bus.mem_wr, grant_id, busy, timeout_err});
    end
    total++;
    if (bus.mem_addr !== 32'h0) begin
      bad++; $display("FAIL reset_addr got=%0h exp=0", bus.mem_addr);
    end
    total++;
    if (bus.mem_wdata !== '0 || bus.req_rdata !== '0) begin
      bad++; $display("FAIL reset_data got=%0h/%0h exp=0", bus.mem_wdata, bus.req_rdata);
    end
  endtask

  task automatic test_single_read();
    bit seen; int unsigned lat; logic [GW-1:0] gid; logic [31:0] addr;
    logic rd, wr; logic [LB-1:0] wdata, rdat; logic [NR-1:0] rdy;
    bus.req_addr[2*32 +: 32] = 32'h0000_1240;
    bus.req_rd[2] = 1'b1;
    run_txn(5, PAT_A5, seen, lat, gid, addr, rd, wr, wdata, rdy, rdat);
    total++;
    if (!seen || lat != 1) begin
      bad++; $display("FAIL rd_latency got=%0d exp=1 (seen=%0d)", lat, seen);
    end
    total++;
    if (addr !== 32'h0000_1240 || gid !== 2'd2 || rd !== 1'b1 || wr !== 1'b0) begin
      bad++; $display("FAIL rd_issue got addr=%0h gid=%0d rd=%0b wr=%0b exp 1240/2/1/0",
                      addr, gid, rd, wr);
    end
    total++;
    if (rdy !== 4'b0100 || rdat !== PAT_A5) begin
      bad++; $display("FAIL rd_complete got rdy=%0b rdata=%0h exp 0100/a5..", rdy, rdat);
    end
    bus.req_rd[2] = 1'b0;
    tick(1);
    total++;
    if (bus.req_ready !== 4'b0000 || busy !== 1'b0 || bus.mem_rd !== 1'b0) begin
      bad++; $display("FAIL rd_release got rdy=%0b busy=%0b mem_rd=%0b exp 0/0/0",
                      bus.req_ready, busy, bus.mem_rd);
    end
  endtask

  task automatic test_contention();
    bit seen; int unsigned lat; logic [GW-1:0] gid; logic [31:0] addr;
    logic rd, wr; logic [LB-1:0] wdata, rdat, pat; logic [NR-1:0] rdy;
    int cnt0 [NR]; int mh0; logic [7:0] b;
    do_reset();
    for (int i = 0; i < int'(NR); i++) begin
      bus.req_addr[i*32 +: 32] = 32'h100 * (i + 1);
      cnt0[i] = ready_cnt[i];
    end
    mh0 = multi_hot;
    bus.req_rd = 4'b1111;
    for (int k = 0; k < int'(NR); k++) begin
      b   = 8'(8'h10 + k);
      pat = {L1_LINE_SIZE{b}};
      run_txn(2, pat, seen, lat, gid, addr, rd, wr, wdata, rdy, rdat);
      total++;
      if (!seen || lat != ((k == 0) ? 1 : 2)) begin
        bad++; $display("FAIL cont_gap%0d got=%0d exp=%0d", k, lat, (k == 0) ? 1 : 2);
      end
      total++;
      if (gid !== GW'(k) || addr !== 32'h100 * (k + 1)) begin
        bad++; $display("FAIL cont_grant%0d got gid=%0d addr=%0h exp %0d/%0h",
                        k, gid, addr, k, 32'h100 * (k + 1));
      end
      total++;
      if (rdy !== NR'(1 << k) || rdat !== pat) begin
        bad++; $display("FAIL cont_ready%0d got rdy=%0b exp=%0b", k, rdy, NR'(1 << k));
      end
      bus.req_rd[k] = 1'b0;
    end
    tick(3);
    for (int i = 0; i < int'(NR); i++) begin
      total++;
      if (ready_cnt[i] - cnt0[i] != 1) begin
        bad++; $display("FAIL cont_once%0d got=%0d exp=1", i, ready_cnt[i] - cnt0[i]);
      end
    end
    total++;
    if (multi_hot != mh0) begin
      bad++; $display("FAIL cont_onehot got=%0d exp=%0d", multi_hot, mh0);
    end
  endtask

  task automatic test_fairness();
    bit seen; int unsigned lat; logic [GW-1:0] gid; logic [31:0] addr;
    logic rd, wr; logic [LB-1:0] wdata, rdat; logic [NR-1:0] rdy;
    bus.req_rd[1] = 1'b1;
    run_txn(1, PAT_C3, seen, lat, gid, addr, rd, wr, wdata, rdy, rdat);
    total++;
    if (gid !== 2'd1 || rdy !== 4'b0010) begin
      bad++; $display("FAIL fair_first got gid=%0d rdy=%0b exp 1/0010", gid, rdy);
    end
    bus.req_rd[1] = 1'b0;
    tick(1);
    bus.req_rd[0] = 1'b1;
    bus.req_rd[1] = 1'b1;
    run_txn(1, PAT_C3, seen, lat, gid, addr, rd, wr, wdata, rdy, rdat);
    total++;
    if (!seen || gid !== 2'd0 || rdy !== 4'b0001) begin
      bad++; $display("FAIL fair_wrap got gid=%0d rdy=%0b exp 0/0001", gid, rdy);
    end
    bus.req_rd[0] = 1'b0;
    run_txn(1, PAT_C3, seen, lat, gid, addr, rd, wr, wdata, rdy, rdat);
    total++;
    if (!seen || gid !== 2'd1 || rdy !== 4'b0010) begin
      bad++; $display("FAIL fair_next got gid=%0d rdy=%0b exp 1/0010", gid, rdy);
    end
    bus.req_rd[1] = 1'b0;
    tick(1);
  endtask

  task automatic test_watchdog();
    bit seen; int unsigned lat; logic [GW-1:0] gid; logic [31:0] addr;
    logic rd, wr; logic [LB-1:0] wdata, rdat; logic [NR-1:0] rdy;
    bus.req_addr[1*32 +: 32] = 32'h0000_2000;
    bus.req_rd[1] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 12 && !seen; n++) begin
      tick(1);
      if (bus.mem_rd) seen = 1'b1;
    end
    total++;
    if (!seen || grant_id !== 2'd1) begin
      bad++; $display("FAIL wd_grant got seen=%0d gid=%0d exp 1/1", seen, grant_id);
    end
    tick(15);
    total++;
    if (bus.req_ready !== 4'b0000 || timeout_err !== 1'b0 || bus.mem_rd !== 1'b1) begin
      bad++; $display("FAIL wd_early got rdy=%0b err=%0b mem_rd=%0b exp 0/0/1",
                      bus.req_ready, timeout_err, bus.mem_rd);
    end
    tick(1);
    total++;
    if (bus.req_ready !== 4'b0010 || bus.mem_rd !== 1'b0) begin
      bad++; $display("FAIL wd_ready got rdy=%0b mem_rd=%0b exp 0010/0", bus.req_ready, bus.mem_rd);
    end
    total++;
    if (bus.req_rdata !== '0 || timeout_err !== 1'b1) begin
      bad++; $display("FAIL wd_result got rdata=%0h err=%0b exp 0/1", bus.req_rdata, timeout_err);
    end
    bus.req_rd[1] = 1'b0;
    tick(2);
    total++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL wd_sticky got err=%0b busy=%0b exp 1/0", timeout_err, busy);
    end
    bus.req_addr[2*32 +: 32] = 32'h0000_3000;
    bus.req_rd[2] = 1'b1;
    run_txn(3, PAT_C3, seen, lat, gid, addr, rd, wr, wdata, rdy, rdat);
    total++;
    if (!seen || gid !== 2'd2 || addr !== 32'h0000_3000 || rdy !== 4'b0100 || rdat !== PAT_C3) begin
      bad++; $display("FAIL wd_after got gid=%0d addr=%0h rdy=%0b exp 2/3000/0100", gid, addr, rdy);
    end
    bus.req_rd[2] = 1'b0;
    tick(1);
  endtask

  task automatic test_write_rerequest();
    bit seen; int unsigned lat; logic [GW-1:0] gid; logic [31:0] addr;
    logic rd, wr; logic [LB-1:0] wdata, rdat; logic [NR-1:0] rdy;
    bit regrant;
    bus.req_addr[0 +: 32] = 32'h0000_4480;
    bus.req_wdata[0 +: LB] = PAT_5A;
    bus.req_wr[0] = 1'b1;
    run_txn(2, PAT_C3, seen, lat, gid, addr, rd, wr, wdata, rdy, rdat);
    total++;
    if (!seen || gid !== 2'd0 || wr !== 1'b1 || rd !== 1'b0 || wdata !== PAT_5A) begin
      bad++; $display("FAIL wr_issue got gid=%0d wr=%0b rd=%0b wdata=%0h exp 0/1/0/5a..",
                      gid, wr, rd, wdata);
    end
    total++;
    if (rdy !== 4'b0001 || rdat !== '0) begin
      bad++; $display("FAIL wr_complete got rdy=%0b rdata=%0h exp 0001/0", rdy, rdat);
    end
    total++;
    if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin
      bad++; $display("FAIL wr_release got mem_rd=%0b mem_wr=%0b exp 0/0", bus.mem_rd, bus.mem_wr);
    end
    @(posedge clk);
    #1;
    bus.req_wr[0] = 1'b0;
    regrant = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick(1);
      if (bus.mem_rd || bus.mem_wr || busy) regrant = 1'b1;
    end
    total++;
    if (regrant) begin
      bad++; $display("FAIL wr_stale got regrant=1 exp 0");
    end
  endtask

  task automatic test_reset_mid_busy();
    bit seen; int unsigned lat; logic [GW-1:0] gid; logic [31:0] addr;
    logic rd, wr; logic [LB-1:0] wdata, rdat; logic [NR-1:0] rdy;
    bus.req_addr[1*32 +: 32] = 32'h0000_5500;
    bus.req_rd[1] = 1'b1;
    tick(2);
    total++;
    if (bus.mem_rd !== 1'b1) begin
      bad++; $display("FAIL rst_setup got mem_rd=%0b exp 1", bus.mem_rd);
    end
    rst_n = 1'b0;
    bus.req_rd[1] = 1'b0;
    bus.req_addr[3*32 +: 32] = 32'h0000_7700;
    bus.req_rd[3] = 1'b1;
    #1;
    total++;
    if ({bus.req_ready, bus.mem_rd, bus.mem_wr, grant_id, busy, timeout_err} !== '0 ||
        bus.mem_addr !== 32'h0 || bus.req_rdata !== '0) begin
      bad++; $display("FAIL rst_mid got ctrl=%0h addr=%0h exp 0/0",
                      {bus.req_ready, bus.mem_rd, bus.mem_wr, grant_id, busy, timeout_err},
                      bus.mem_addr);
    end
    tick(2);
    rst_n = 1'b1;
    run_txn(1, PAT_A5, seen, lat, gid, addr, rd, wr, wdata, rdy, rdat);
    total++;
    if (!seen || lat != 1 || gid !== 2'd3 || addr !== 32'h0000_7700 || rdy !== 4'b1000) begin
      bad++; $display("FAIL rst_regrant got lat=%0d gid=%0d addr=%0h rdy=%0b exp 1/3/7700/1000",
                      lat, gid, addr, rdy);
    end
    bus.req_rd[3] = 1'b0;
    tick(2);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    tick(2);
    test_reset();
    rst_n = 1'b1;
    tick(1);
    test_single_read();
    test_contention();
    test_fairness();
    test_watchdog();
    test_write_rerequest();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
